// File: rtl/alu_request_scheduler_pkg.sv
// Shared types for the ALU request scheduler: ALU op codes and scheduler FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/alu_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer,
// pointer moves to one past the served requester on an advance strobe.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic                       i_advance,
    input  logic [$clog2(N_REQ)-1:0]   i_advanceIdx,
    output logic [N_REQ-1:0]           o_grant,
    output logic [$clog2(N_REQ)-1:0]   o_grantIdx,
    output logic                       o_grantValid
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;

    // Walk N_REQ candidates from the pointer, wrapping, and keep the first set bit.
    always_comb begin
        o_grant      = '0;
        o_grantIdx   = '0;
        o_grantValid = 1'b0;
        w_cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (!o_grantValid && i_req[w_cand[IDX_W-1:0]]) begin
                o_grantValid                = 1'b1;
                o_grantIdx                  = w_cand[IDX_W-1:0];
                o_grant[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            if (i_advanceIdx == IDX_W'(N_REQ-1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= i_advanceIdx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one sequential ALU between N_REQ requesters: round-robin grant, operand
// latch, start/finish handshake, and a watchdog that aborts hung transactions.
module alu_request_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    req_op,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic [2*DATA_W-1:0]   result,
    output logic                  alu_start,
    output logic [1:0]            alu_op,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_finish,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES-1);

    state_e               r_state;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_done;
    logic                 r_err;
    logic [2*DATA_W-1:0]  r_result;
    logic                 r_aluStart;
    op_e                  r_aluOp;
    logic [DATA_W-1:0]    r_aluA;
    logic [DATA_W-1:0]    r_aluB;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_winner;
    logic [WD_W-1:0]      r_wdog;

    logic [N_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]     w_grantIdx;
    logic                 w_grantValid;
    logic                 w_advance;
    logic [WD_W-1:0]      w_wdogNext;
    logic                 w_wdogExpire;
    logic [1:0]           w_reqOp [N_REQ];
    logic [DATA_W-1:0]    w_reqA  [N_REQ];
    logic [DATA_W-1:0]    w_reqB  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_reqOp[g] = req_op[2*g +: 2];
        assign w_reqA[g]  = req_a[DATA_W*g +: DATA_W];
        assign w_reqB[g]  = req_b[DATA_W*g +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_advance    (w_advance),
        .i_advanceIdx (r_winner),
        .o_grant      (w_grant),
        .o_grantIdx   (w_grantIdx),
        .o_grantValid (w_grantValid)
    );

    assign w_advance = (r_state == RESP);

    // Saturating watchdog; expiry fires in the WAIT cycle where the count reaches WDOG_CYCLES-1.
    assign w_wdogNext   = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
    assign w_wdogExpire = (w_wdogNext == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_aluStart <= 1'b0;
            r_aluOp    <= OP_ADD;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_busy     <= 1'b0;
            r_winner   <= '0;
            r_wdog     <= '0;
        end else begin
            r_aluStart <= 1'b0;
            r_done     <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_winner   <= w_grantIdx;
                        r_aluOp    <= op_e'(w_reqOp[w_grantIdx]);
                        r_aluA     <= w_reqA[w_grantIdx];
                        r_aluB     <= w_reqB[w_grantIdx];
                        r_gnt      <= w_grant;
                        r_aluStart <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_wdog <= w_wdogNext;
                    // A finish on the expiry cycle still counts as a good completion.
                    if (alu_finish) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                        r_done   <= r_gnt;
                        r_state  <= RESP;
                    end else if (w_wdogExpire) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= r_gnt;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_gnt    <= '0;
                    r_result <= '0;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign alu_start = r_aluStart;
    assign alu_op    = r_aluOp;
    assign alu_a     = r_aluA;
    assign alu_b     = r_aluB;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Self-checking bench for alu_request_scheduler: directed scenarios plus randomized
// transactions against a transaction-level round-robin / ALU reference model.
module tb_alu_request_scheduler;
    import alu_pkg::*;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int WD_TEST = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT (default watchdog) signals
    logic [N-1:0]    req;
    logic [2*N-1:0]  reqOpVec;
    logic [DW*N-1:0] reqAVec, reqBVec;
    logic [N-1:0]    gnt, done;
    logic            err, aluStart, aluFinish, busy;
    logic [2*DW-1:0] result, aluResult;
    logic [1:0]      aluOp;
    logic [DW-1:0]   aluA, aluB;

    logic [1:0]      opArr [N];
    logic [DW-1:0]   aArr [N];
    logic [DW-1:0]   bArr [N];

    // Short-watchdog DUT signals
    logic [N-1:0]    wReq;
    logic [2*N-1:0]  wOpVec;
    logic [DW*N-1:0] wAVec, wBVec;
    logic [N-1:0]    wGnt, wDone;
    logic            wErr, wAluStart, wFinish, wBusy;
    logic [2*DW-1:0] wResult, wAluResult;
    logic [1:0]      wAluOp;
    logic [DW-1:0]   wAluA, wAluB;

    int assertCount = 0;
    int failCount   = 0;
    int modelPtr    = 0;

    int          aluLatency  = 5;
    bit          aluPending  = 1'b0;
    int          aluCount    = 0;
    logic [15:0] aluValue    = '0;
    int          strayReq    = 0;
    int          strayServed = 0;

    always_comb begin
        reqOpVec = '0;
        reqAVec  = '0;
        reqBVec  = '0;
        for (int i = 0; i < N; i++) begin
            reqOpVec[2*i +: 2] = opArr[i];
            reqAVec[DW*i +: DW] = aArr[i];
            reqBVec[DW*i +: DW] = bArr[i];
        end
    end

    alu_request_scheduler #(.N_REQ(N), .DATA_W(DW), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(reqOpVec), .req_a(reqAVec), .req_b(reqBVec),
        .gnt(gnt), .done(done), .err(err), .result(result), .alu_start(aluStart),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_finish(aluFinish),
        .alu_result(aluResult), .busy(busy)
    );

    alu_request_scheduler #(.N_REQ(N), .DATA_W(DW), .WDOG_CYCLES(WD_TEST)) dutWd (
        .clk(clk), .rst(rst), .req(wReq), .req_op(wOpVec), .req_a(wAVec), .req_b(wBVec),
        .gnt(wGnt), .done(wDone), .err(wErr), .result(wResult), .alu_start(wAluStart),
        .alu_op(wAluOp), .alu_a(wAluA), .alu_b(wAluB), .alu_finish(wFinish),
        .alu_result(wAluResult), .busy(wBusy)
    );

    function automatic logic [15:0] aluFunc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return 16'(a) + 16'(b);
            2'b01:   return {8'h00, 8'(a - b)};
            2'b10:   return 16'(a) * 16'(b);
            default: return (b == 8'd0) ? 16'hFFFF : 16'(a / b);
        endcase
    endfunction

    function automatic int rrPick(input logic [N-1:0] mask, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        opArr[ch] = op;
        aArr[ch]  = a;
        bArr[ch]  = b;
    endtask

    // Environment ALU: answers each start after aluLatency cycles; also emits stray finishes.
    initial begin
        aluFinish = 1'b0;
        aluResult = '0;
        forever begin
            @(posedge clk);
            #1;
            aluFinish = 1'b0;
            aluResult = '0;
            if (rst == 1'b0) begin
                aluPending = 1'b0;
            end else if (aluPending) begin
                if (aluCount <= 1) begin
                    aluFinish  = 1'b1;
                    aluResult  = aluValue;
                    aluPending = 1'b0;
                end else begin
                    aluCount--;
                end
            end
            if (strayReq != strayServed) begin
                strayServed = strayReq;
                aluFinish   = 1'b1;
                aluResult   = 16'hBEEF;
            end
            if (aluStart && rst) begin
                aluPending = 1'b1;
                aluCount   = aluLatency;
                aluValue   = aluFunc(aluOp, aluA, aluB);
            end
        end
    end

    task automatic runTransaction(input logic [N-1:0] mask, input int latency, input bit dropReq,
                                  input bit mutate, input string tag);
        int win;
        int c;
        logic [1:0]   eOp;
        logic [7:0]   eA, eB;
        logic [15:0]  eRes;
        logic [N-1:0] eOneHot;
        aluLatency = latency;
        req = mask;
        win = rrPick(mask, modelPtr);
        if (win < 0) begin
            tick();
            checkOutput({tag, "_idleGnt"}, 32'(gnt), 32'd0);
            checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
            return;
        end
        eOp     = opArr[win];
        eA      = aArr[win];
        eB      = bArr[win];
        eRes    = aluFunc(eOp, eA, eB);
        eOneHot = N'(1 << win);
        tick();
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(eOneHot));
        checkOutput({tag, "_start"}, 32'(aluStart), 32'd1);
        checkOutput({tag, "_aluOp"}, 32'(aluOp), 32'(eOp));
        checkOutput({tag, "_aluA"}, 32'(aluA), 32'(eA));
        checkOutput({tag, "_aluB"}, 32'(aluB), 32'(eB));
        if (dropReq) req[win] = 1'b0;
        if (mutate) applyStimulus(win, ~eOp, ~eA, eB + 8'd1);
        c = 0;
        do begin
            tick();
            c++;
            if (c == 1) checkOutput({tag, "_startPulse"}, 32'(aluStart), 32'd0);
        end while (done == '0 && c < latency + 8);
        checkOutput({tag, "_doneLatency"}, 32'(c), 32'(latency + 1));
        checkOutput({tag, "_done"}, 32'(done), 32'(eOneHot));
        checkOutput({tag, "_result"}, 32'(result), 32'(eRes));
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_gntHeld"}, 32'(gnt), 32'(eOneHot));
        checkOutput({tag, "_aluAHeld"}, 32'(aluA), 32'(eA));
        checkOutput({tag, "_aluBHeld"}, 32'(aluB), 32'(eB));
        tick();
        checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_gntClear"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_busyClear"}, 32'(busy), 32'd0);
        modelPtr = (win + 1) % N;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_result"}, 32'(result), 32'd0);
        checkOutput({tag, "_start"}, 32'(aluStart), 32'd0);
        checkOutput({tag, "_aluOp"}, 32'(aluOp), 32'd0);
        checkOutput({tag, "_aluA"}, 32'(aluA), 32'd0);
        checkOutput({tag, "_aluB"}, 32'(aluB), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic resetMidOp(input logic [N-1:0] startMask, input logic [N-1:0] afterMask, input string tag);
        int win;
        aluLatency = 30;
        req = startMask;
        win = rrPick(startMask, modelPtr);
        tick();
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(1 << win));
        repeat (3) tick();
        checkOutput({tag, "_busyWait"}, 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        checkAllZero({tag, "_zero"});
        tick();
        checkOutput({tag, "_noDone"}, 32'(done), 32'd0);
        rst = 1'b1;
        modelPtr = 0;
        runTransaction(afterMask, 5, 1'b0, 1'b0, {tag, "_after"});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int c;
        rst = 1'b0;
        req = '0;
        wReq = '0; wOpVec = '0; wAVec = '0; wBVec = '0; wFinish = 1'b0; wAluResult = '0;
        for (int i = 0; i < N; i++) applyStimulus(i, 2'b00, 8'd0, 8'd0);
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        modelPtr = 0;

        $display("[TB] single request");
        applyStimulus(0, OP_MUL, 8'd12, 8'd11);
        runTransaction(4'b0001, 20, 1'b0, 1'b0, "single");

        $display("[TB] contention");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        modelPtr = 0;
        for (int i = 0; i < N; i++) applyStimulus(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 5; k++) runTransaction(4'b1111, 3 + k, 1'b0, 1'b0, $sformatf("contend%0d", k));

        $display("[TB] req drop and operand change after grant");
        applyStimulus(1, OP_SUB, 8'd50, 8'd7);
        runTransaction(4'b0010, 6, 1'b1, 1'b1, "drop");

        $display("[TB] stray finish while idle");
        req = '0;
        strayReq++;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("stray_done%0d", k), 32'(done), 32'd0);
            checkOutput($sformatf("stray_busy%0d", k), 32'(busy), 32'd0);
        end

        $display("[TB] randomized transactions");
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) applyStimulus(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            runTransaction(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(1, 12),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("[TB] reset mid-operation");
        resetMidOp(4'b0010, 4'b0100, "rst1");
        runTransaction(4'b0010, 4, 1'b0, 1'b0, "preRst2");
        resetMidOp(4'b0100, 4'b1001, "rst2");
        req = '0;

        $display("[TB] watchdog abort");
        wAVec = {8'd40, 8'd30, 8'd20, 8'd10};
        wBVec = {8'd4, 8'd3, 8'd2, 8'd1};
        wOpVec = 8'b00_10_01_00;
        wReq = 4'b0010;
        tick();
        checkOutput("wd_gnt", 32'(wGnt), 32'h2);
        checkOutput("wd_start", 32'(wAluStart), 32'd1);
        wReq = '0;
        c = 0;
        do begin
            tick();
            c++;
        end while (wDone == '0 && c < 40);
        checkOutput("wd_latency", 32'(c), 32'(WD_TEST));
        checkOutput("wd_done", 32'(wDone), 32'h2);
        checkOutput("wd_err", 32'(wErr), 32'd1);
        checkOutput("wd_result", 32'(wResult), 32'd0);
        tick();
        checkOutput("wd_idle", 32'(wBusy), 32'd0);

        wReq = 4'b0001;
        tick();
        checkOutput("wd_next_gnt", 32'(wGnt), 32'h1);
        wReq = '0;
        tick();
        tick();
        wFinish = 1'b1;
        wAluResult = 16'h1234;
        tick();
        wFinish = 1'b0;
        wAluResult = '0;
        checkOutput("wd_next_done", 32'(wDone), 32'h1);
        checkOutput("wd_next_err", 32'(wErr), 32'd0);
        checkOutput("wd_next_result", 32'(wResult), 32'h1234);
        tick();

        $display("[TB] finish coincides with watchdog expiry");
        wReq = 4'b0100;
        tick();
        checkOutput("co_gnt", 32'(wGnt), 32'h4);
        wReq = '0;
        for (int j = 1; j < WD_TEST; j++) begin
            tick();
            checkOutput($sformatf("co_noDone%0d", j), 32'(wDone), 32'd0);
        end
        wFinish = 1'b1;
        wAluResult = 16'h00FF;
        tick();
        wFinish = 1'b0;
        wAluResult = '0;
        checkOutput("co_done", 32'(wDone), 32'h4);
        checkOutput("co_err", 32'(wErr), 32'd0);
        checkOutput("co_result", 32'(wResult), 32'h00FF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_request_scheduler.md
Name: alu_request_scheduler

Overview:
Shares the single sequential ALU (control unit plus datapath; add/sub/multiply/divide selected by 2-bit op code) between N_REQ independent requesters. Arbitrates round-robin and latches the winner's op code and operands. Drives the ALU start pulse, waits for its finish pulse, and returns the 16-bit result to the granted requester. A watchdog aborts transactions whose finish never arrives.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand width; result width is 2*DATA_W
WDOG_CYCLES, 64, max cycles in WAIT before abort (>=16, must exceed worst ALU latency)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
req  input  N_REQ  per-requester request level
req_op  input  2*N_REQ  per-requester op code, slice i = [2i+1:2i]; 00 add, 01 sub, 10 mul, 11 div
req_a  input  DATA_W*N_REQ  per-requester operand A
req_b  input  DATA_W*N_REQ  per-requester operand B
gnt  output  N_REQ  one-hot grant, held from ISSUE through RESP
done  output  N_REQ  one-hot, one-cycle completion pulse
err  output  1  valid with done; 1 = watchdog abort
result  output  2*DATA_W  result, valid while any done bit is 1
alu_start  output  1  one-cycle start pulse to control unit
alu_op  output  2  latched op code to control unit
alu_a  output  DATA_W  latched operand A
alu_b  output  DATA_W  latched operand B
alu_finish  input  1  finish pulse from control unit
alu_result  input  2*DATA_W  ALU result, valid when alu_finish=1
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, rr pointer=0, and gnt, done, err, result, alu_start, alu_op, alu_a, alu_b, busy all 0. Reset mid-transaction aborts silently with no done pulse. Behaviour of any ALU still running is the control unit's concern; it shares the same rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is 1, pick the winner round-robin. Search starts at pointer, wraps modulo N_REQ, and takes the first set bit. Latch the winner index, op, a and b into alu_* registers and set gnt one-hot. Go to ISSUE next cycle. If req=0, stay in IDLE.
- ISSUE: alu_start=1 for exactly this cycle, clear watchdog counter, go to WAIT.
- WAIT: alu_* stay stable; watchdog increments each cycle.
  - alu_finish=1: capture alu_result into result, set err=0, go to RESP.
  - Else, if watchdog reaches WDOG_CYCLES-1: set result=0, err=1, go to RESP.
  - alu_finish and watchdog expiry in the same cycle: finish wins, err=0.
- RESP: done[winner]=1 for one cycle; result and err valid. Pointer becomes (winner+1) mod N_REQ. gnt cleared on exit. Return to IDLE, so there is at least 1 idle cycle between transactions.
- Latency: req sampled in IDLE at edge k; alu_start high during cycle k+1; done appears 1 cycle after alu_finish is sampled.
- Requesters must hold req until done. A req deassertion after grant is ignored: the transaction completes and done still pulses. The requester's op/a/b may change after grant with no effect, since they are latched.
- Simultaneous requests: strict round-robin, so a persistently requesting channel waits at most N_REQ-1 transactions.
- alu_finish outside WAIT is ignored.
- Width rules: add/sub results are zero-extended by the ALU. The scheduler passes result bits unmodified; no arithmetic is done here.
- Watchdog counter width: $clog2(WDOG_CYCLES). It saturates and never wraps.

Decomposition:
- Shared package alu_pkg: op code typedef (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11) and scheduler state enum (IDLE, ISSUE, WAIT, RESP).
- Sub-module rr_arbiter (parameter N_REQ): combinational one-hot winner from req and pointer, plus a registered pointer update on an advance strobe.
- FSM, watchdog and latches live in alu_request_scheduler.

Test Plan:
- Single request: req=0001, op=10, a=8'd12, b=8'd11. Model ALU asserts alu_finish 20 cycles after start with result 16'd132. Required: gnt=0001, alu_start pulse 1 cycle after req, done=0001 1 cycle after finish, result=16'd132, err=0.
- Contention: req=1111 held, pointer=0. Required: grant order 0,1,2,3,0 across five transactions. Each done pulse is exactly one cycle and one-hot.
- Watchdog: WDOG_CYCLES=16 and model ALU never finishes. Required: done pulse with err=1, result=0, 16 cycles after ISSUE. The next request is served normally.
- Finish and watchdog coincide: alu_finish lands on the expiry cycle with result 16'h00FF. Required: err=0, result=16'h00FF.
- Reset mid-operation: rst=0 during WAIT. Required: next cycle all outputs 0, state IDLE, no done pulse, pointer=0. After rst=1, req=0100 is granted immediately.
- Stray and late signals: alu_finish pulse while IDLE produces no done. req drop after grant: done still pulses for that requester, and operand changes after grant do not change alu_a or alu_b.
